bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
//  Converts a WIDTH-bit unsigned value into DIGITS packed BCD digits, one bit per clock.
//  Provides a Start/Done handshake, an overflow flag and a leading-zero blanking mask.
//  Sits between switch/counter datapaths and the seven-segment display drivers.
// PARAMETERS
//  WIDTH   8  width of binary input Bin (1..32)
//  DIGITS  3  number of BCD digits produced (1..10); digit 0 = ones
// PORTS
//  Clock     in   1          rising-edge clock
//  Reset     in   1          asynchronous, active-high reset
//  Start     in   1          request conversion of Bin; honoured only when Busy=0
//  Bin       in   WIDTH      unsigned binary value, sampled on accepting edge only
//  Busy      out  1          high while a conversion is in progress (state SHIFT)
//  Done      out  1          one-cycle pulse: BCD/Overflow/Blank just updated
//  BCD       out  4*DIGITS   result; digit i at BCD[4i+3:4i]
//  Overflow  out  1          Bin >= 10**DIGITS; BCD then holds Bin mod 10**DIGITS
//  Blank     out  DIGITS     Blank[i]=1 -> digit i is a leading zero; Blank[0] always 0
// BEHAVIOUR
//  Reset (async, any time, incl. mid-conversion): state=IDLE, Busy=0, Done=0, BCD=0,
//   Overflow=0, Blank={DIGITS-1{1},0}; in-flight conversion discarded, no Done issued.
//  States: IDLE, SHIFT, DONE.
//   IDLE/DONE + Start=1 -> SHIFT: bin_sr<=Bin, bcd_sr<=0, ovf_acc<=0, cnt<=0.
//   IDLE + Start=0 -> IDLE; DONE + Start=0 -> IDLE (DONE lasts exactly one cycle).
//   SHIFT: per edge, every digit of bcd_sr >=5 gets +3 (all digits in parallel, before
//    the shift), then {carry,bcd_sr,bin_sr} shifted left 1; carry = bit leaving top
//    digit; ovf_acc <= ovf_acc | carry; cnt++.
//   SHIFT with cnt==WIDTH-1 -> DONE; same edge loads BCD, Overflow, Blank from the
//    final shifted values and sets Done=1.
//  Latency: Start sampled at edge k -> Done high in cycle after edge k+WIDTH
//   (WIDTH+1 clocks). Busy=1 after edge k through edge k+WIDTH-1 inclusive.
//  Start while Busy=1: ignored, no effect on state, Bin not re-sampled.
//  Start in the Done cycle: accepted (back-to-back), Done still pulses once.
//  Outputs BCD/Overflow/Blank are registered, hold value until the next Done.
//  Blank: computed from final digits; digit i (i>=1) blanked iff it and all higher
//   digits are zero. Overflow=1 forces Blank=0 (all digits shown).
//  Add-3 correction is 4-bit; digits never exceed 9 after a correct conversion.
//  Bin=0 is legal: BCD=0, Overflow=0.
// TESTING
//  T1 WIDTH=8,DIGITS=3: Start,Bin=8'd255 -> Done exactly 9 clks later, BCD=12'h255,
//     Overflow=0, Blank=3'b000; Busy high 8 cycles.
//  T2 WIDTH=8,DIGITS=3: Bin=0 -> BCD=12'h000, Blank=3'b110; Bin=7 -> BCD=12'h007,
//     Blank=3'b110; Bin=42 -> BCD=12'h042, Blank=3'b100.
//  T3 WIDTH=8,DIGITS=2: Bin=200 -> BCD=8'h00, Overflow=1, Blank=2'b00; then Bin=99 ->
//     BCD=8'h99, Overflow=0.
//  T4 Start with Bin=100, then Start with Bin=55 while Busy -> only one Done, BCD=12'h100;
//     Start in the Done cycle with Bin=55 -> second Done 9 clks later, BCD=12'h055.
//  T5 Reset asserted mid-SHIFT (cnt=4), async between edges -> outputs to reset values
//     immediately, no Done; next Start,Bin=13 -> BCD=12'h013.
//  T6 WIDTH=4,DIGITS=2: sweep Bin 0..15 -> BCD matches decimal (e.g. 13 -> 8'h13),
//     Overflow=0 throughout; random WIDTH=16,DIGITS=5 vs model, 1000 values.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/Done handshake and registered result bus of the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy/done and the BCD result.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow, blank
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock; Start->Done latency WIDTH+1 clocks.
// No backpressure: start is only honoured when not busy (IDLE or the one-cycle DONE state).
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bin2bcd_seq_if.slave conv_if
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0]     LAST      = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
  logic [BW-1:0]     bcd_sr_q, bcd_sr_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     bcd_shift;
  logic              carry;
  logic              ovf_next;
  logic              all_zero;
  logic [DIGITS-1:0] blank_next;

  // One double-dabble step: add-3 on every digit in parallel, then shift.
  always_comb begin
    adj = bcd_sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
      end
    end
    carry     = adj[BW-1];
    bcd_shift = {adj[BW-2:0], bin_sr_q[WIDTH-1]};
    ovf_next  = ovf_acc_q | carry;

    // Leading-zero mask scans down from the top digit; an overflowed value shows every digit.
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (bcd_shift[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero & ~ovf_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_sr_d  = bcd_sr_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    case (state_q)
      SHIFT: begin
        bin_sr_d  = bin_sr_q << 1;
        bcd_sr_d  = bcd_shift;
        ovf_acc_d = ovf_next;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bcd_d   = bcd_shift;
          ovf_d   = ovf_next;
          blank_d = blank_next;
        end
      end
      default: begin
        state_d = IDLE;
        if (conv_if.start) begin
          state_d   = SHIFT;
          bin_sr_d  = conv_if.bin;
          bcd_sr_d  = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      bcd_sr_q  <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= BLANK_RST;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_sr_q  <= bcd_sr_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign conv_if.busy     = (state_q == SHIFT);
  assign conv_if.done     = (state_q == DONE);
  assign conv_if.bcd      = bcd_q;
  assign conv_if.overflow = ovf_q;
  assign conv_if.blank    = blank_q;
endmodule
